// File: rtl/complex_matrix_addsub_stream.sv
// Complex matrix add/subtract engine: one SIZE-element job per handshake, LANES complex
// adders per beat over SIZE/LANES beats, with optional saturation, sticky overflow and a tag.
module complex_matrix_addsub_stream #(
    parameter int WIDTH     = 16,
    parameter int SIZE      = 16,
    parameter int LANES     = 4,
    parameter int TAG_WIDTH = 1
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              in_valid_i,
    output logic                              in_ready_o,
    input  logic [SIZE*4-1:0][WIDTH-1:0]      operands_i,
    input  logic [1:0]                        op_i,
    input  logic                              sat_i,
    input  logic [TAG_WIDTH-1:0]              tag_i,
    input  logic                              flush_i,
    output logic [SIZE*2-1:0][WIDTH-1:0]      result_o,
    output logic                              ovf_o,
    output logic [TAG_WIDTH-1:0]              tag_o,
    output logic                              out_valid_o,
    input  logic                              out_ready_i,
    output logic                              busy_o
);

    localparam int BEATS  = SIZE / LANES;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int ELEM_W = (SIZE > 1) ? $clog2(SIZE) : 1;

    if ((SIZE % LANES) != 0) begin : gen_bad_lanes
        $error("complex_matrix_addsub_stream: SIZE must be a multiple of LANES");
    end
    if (WIDTH < 2) begin : gen_bad_width
        $error("complex_matrix_addsub_stream: WIDTH must be at least 2");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e                          state_q, state_d;
    logic [BEAT_W-1:0]               beat_q, beat_d;
    logic [SIZE*4-1:0][WIDTH-1:0]    operands_q, operands_d;
    logic [1:0]                      op_q, op_d;
    logic                            sat_q, sat_d;
    logic [TAG_WIDTH-1:0]            tag_q, tag_d;
    logic                            ovf_q, ovf_d;
    logic [SIZE*2-1:0][WIDTH-1:0]    result_q, result_d;

    logic [LANES-1:0][WIDTH-1:0]     laneRe, laneIm;
    logic [LANES-1:0][ELEM_W-1:0]    laneElem;
    logic [LANES-1:0]                laneOvf;
    logic signed [WIDTH:0]           aRe, aIm, bRe, bIm, sumRe, sumIm;

    // The (WIDTH+1)-bit sum overflows WIDTH exactly when its top two bits disagree.
    function automatic logic [WIDTH-1:0] fitWidth(input logic signed [WIDTH:0] s, input logic sat);
        logic [WIDTH-1:0] r;
        r = s[WIDTH-1:0];
        if (sat && (s[WIDTH] != s[WIDTH-1])) begin
            r = s[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
        return r;
    endfunction

    always_comb begin
        laneRe   = '0;
        laneIm   = '0;
        laneElem = '0;
        laneOvf  = '0;
        aRe      = '0;
        aIm      = '0;
        bRe      = '0;
        bIm      = '0;
        sumRe    = '0;
        sumIm    = '0;
        for (int l = 0; l < LANES; l++) begin
            laneElem[l] = ELEM_W'(int'(beat_q) * LANES + l);
            aRe = {operands_q[{laneElem[l], 2'd0}][WIDTH-1], operands_q[{laneElem[l], 2'd0}]};
            aIm = {operands_q[{laneElem[l], 2'd1}][WIDTH-1], operands_q[{laneElem[l], 2'd1}]};
            bRe = {operands_q[{laneElem[l], 2'd2}][WIDTH-1], operands_q[{laneElem[l], 2'd2}]};
            bIm = {operands_q[{laneElem[l], 2'd3}][WIDTH-1], operands_q[{laneElem[l], 2'd3}]};
            case (op_q)
                2'd0:    begin sumRe = aRe + bRe; sumIm = aIm + bIm; end
                2'd1:    begin sumRe = aRe - bRe; sumIm = aIm - bIm; end
                2'd2:    begin sumRe = aRe + bRe; sumIm = aIm - bIm; end
                default: begin sumRe = bRe - aRe; sumIm = bIm - aIm; end
            endcase
            laneOvf[l] = (sumRe[WIDTH] != sumRe[WIDTH-1]) || (sumIm[WIDTH] != sumIm[WIDTH-1]);
            laneRe[l]  = fitWidth(sumRe, sat_q);
            laneIm[l]  = fitWidth(sumIm, sat_q);
        end
    end

    // Flush also clears ovf/tag so nothing from an aborted job is visible afterwards.
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        operands_d = operands_q;
        op_d       = op_q;
        sat_d      = sat_q;
        tag_d      = tag_q;
        ovf_d      = ovf_q;
        result_d   = result_q;
        if (flush_i) begin
            state_d = IDLE;
            ovf_d   = 1'b0;
            tag_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        state_d    = RUN;
                        beat_d     = '0;
                        operands_d = operands_i;
                        op_d       = op_i;
                        sat_d      = sat_i;
                        tag_d      = tag_i;
                        ovf_d      = 1'b0;
                    end
                end
                RUN: begin
                    for (int l = 0; l < LANES; l++) begin
                        result_d[{laneElem[l], 1'b0}] = laneRe[l];
                        result_d[{laneElem[l], 1'b1}] = laneIm[l];
                    end
                    ovf_d = ovf_q | (|laneOvf);
                    if (beat_q == BEAT_W'(BEATS - 1)) begin
                        state_d = DONE;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            operands_q <= '0;
            op_q       <= '0;
            sat_q      <= 1'b0;
            tag_q      <= '0;
            ovf_q      <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            operands_q <= operands_d;
            op_q       <= op_d;
            sat_q      <= sat_d;
            tag_q      <= tag_d;
            ovf_q      <= ovf_d;
            result_q   <= result_d;
        end
    end

    assign in_ready_o  = (state_q == IDLE) && !rst_i && !flush_i;
    assign out_valid_o = (state_q == DONE);
    assign busy_o      = (state_q != IDLE);
    assign result_o    = result_q;
    assign ovf_o       = ovf_q;
    assign tag_o       = tag_q;

endmodule

// File: tb/tb_complex_matrix_addsub_stream.sv
// Scoreboard bench: three DUT configurations (W16/L4, W8/L1, W32/L16) checked against an
// integer-arithmetic reference model, plus directed overflow, backpressure, flush and reset cases.
module tb_complex_matrix_addsub_stream;

    localparam int NDUT = 3;

    typedef struct packed {
        logic [31:0][31:0] res;
        logic              ovf;
        logic              tag;
        int                acc;
    } exp_t;

    logic clk = 1'b0;
    initial forever #5 clk = ~clk;

    logic [2:0]        rst, inValid, inReady, satSh, tagIn, flush, outValid, outReady, busy, ovf, tagOut;
    logic [1:0]        opSh [NDUT];
    logic [63:0][31:0] opsSh [NDUT];
    logic [63:0][15:0] ops0;
    logic [63:0][7:0]  ops1;
    logic [63:0][31:0] ops2;
    logic [31:0][15:0] res0;
    logic [31:0][7:0]  res1;
    logic [31:0][31:0] res2;
    int                rdyMode [NDUT] = '{1, 0, 0};
    int                cyc;
    int                checks;
    int                errors;
    exp_t              sbQ [NDUT][$];
    logic [2:0]        prevValid;

    always_comb begin
        for (int k = 0; k < 64; k++) begin
            ops0[k] = opsSh[0][k][15:0];
            ops1[k] = opsSh[1][k][7:0];
        end
    end
    assign ops2 = opsSh[2];

    complex_matrix_addsub_stream #(.WIDTH(16), .SIZE(16), .LANES(4), .TAG_WIDTH(1)) dut0 (
        .clk_i(clk), .rst_i(rst[0]), .in_valid_i(inValid[0]), .in_ready_o(inReady[0]),
        .operands_i(ops0), .op_i(opSh[0]), .sat_i(satSh[0]), .tag_i(tagIn[0]), .flush_i(flush[0]),
        .result_o(res0), .ovf_o(ovf[0]), .tag_o(tagOut[0]), .out_valid_o(outValid[0]),
        .out_ready_i(outReady[0]), .busy_o(busy[0]));

    complex_matrix_addsub_stream #(.WIDTH(8), .SIZE(16), .LANES(1), .TAG_WIDTH(1)) dut1 (
        .clk_i(clk), .rst_i(rst[1]), .in_valid_i(inValid[1]), .in_ready_o(inReady[1]),
        .operands_i(ops1), .op_i(opSh[1]), .sat_i(satSh[1]), .tag_i(tagIn[1]), .flush_i(flush[1]),
        .result_o(res1), .ovf_o(ovf[1]), .tag_o(tagOut[1]), .out_valid_o(outValid[1]),
        .out_ready_i(outReady[1]), .busy_o(busy[1]));

    complex_matrix_addsub_stream #(.WIDTH(32), .SIZE(16), .LANES(16), .TAG_WIDTH(1)) dut2 (
        .clk_i(clk), .rst_i(rst[2]), .in_valid_i(inValid[2]), .in_ready_o(inReady[2]),
        .operands_i(ops2), .op_i(opSh[2]), .sat_i(satSh[2]), .tag_i(tagIn[2]), .flush_i(flush[2]),
        .result_o(res2), .ovf_o(ovf[2]), .tag_o(tagOut[2]), .out_valid_o(outValid[2]),
        .out_ready_i(outReady[2]), .busy_o(busy[2]));

    function automatic int widthOf(input int d);
        case (d)
            0:       return 16;
            1:       return 8;
            default: return 32;
        endcase
    endfunction

    function automatic int beatsOf(input int d);
        case (d)
            0:       return 4;
            1:       return 16;
            default: return 1;
        endcase
    endfunction

    function automatic logic [31:0][31:0] gotRes(input int d);
        logic [31:0][31:0] g;
        for (int k = 0; k < 32; k++) begin
            case (d)
                0:       g[k] = 32'(res0[k]);
                1:       g[k] = 32'(res1[k]);
                default: g[k] = res2[k];
            endcase
        end
        return g;
    endfunction

    // Exact integer result, then clamp or wrap into w bits.
    function automatic logic [31:0] fitComp(input longint v, input int w, input bit s, output bit o);
        longint lim;
        lim = longint'(1) <<< (w - 1);
        o = (v > lim - 1) || (v < -lim);
        if (o && s) v = (v < 0) ? -lim : lim - 1;
        return 32'(v) & 32'((longint'(1) <<< w) - 1);
    endfunction

    function automatic exp_t refModel(input int w, input logic [63:0][31:0] ops, input logic [1:0] op,
                                      input bit s, input bit t);
        exp_t   e;
        bit     oRe, oIm;
        longint ar, ai, br, bi, re, im;
        e = '0;
        e.tag = t;
        for (int i = 0; i < 16; i++) begin
            ar = longint'($signed(ops[4*i]));
            ai = longint'($signed(ops[4*i+1]));
            br = longint'($signed(ops[4*i+2]));
            bi = longint'($signed(ops[4*i+3]));
            case (op)
                2'd0:    begin re = ar + br; im = ai + bi; end
                2'd1:    begin re = ar - br; im = ai - bi; end
                2'd2:    begin re = ar + br; im = ai - bi; end
                default: begin re = br - ar; im = bi - ai; end
            endcase
            e.res[2*i]   = fitComp(re, w, s, oRe);
            e.res[2*i+1] = fitComp(im, w, s, oIm);
            e.ovf = e.ovf | oRe | oIm;
        end
        return e;
    endfunction

    function automatic longint randVal(input int w);
        longint lim;
        longint v;
        lim = longint'(1) <<< (w - 1);
        case ($urandom_range(0, 5))
            0: v = lim - 1;
            1: v = -lim;
            2: v = -1;
            default: begin
                v = longint'({$urandom(), $urandom()});
                v = (v <<< (64 - w)) >>> (64 - w);
            end
        endcase
        return v;
    endfunction

    task automatic checkOutput(input string name, input longint got, input longint expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, got, expv);
        end
    endtask

    task automatic checkResult(input string name, input int d, input exp_t e);
        logic [31:0][31:0] g;
        int bad;
        g = gotRes(d);
        bad = -1;
        for (int k = 0; k < 32; k++) if (bad < 0 && g[k] != e.res[k]) bad = k;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("[TB] FAIL %s dut%0d component %0d: got %0h, expected %0h", name, d, bad, g[bad], e.res[bad]);
        end
        checkOutput({name, "_ovf"}, longint'(ovf[d]), longint'(e.ovf));
        checkOutput({name, "_tag"}, longint'(tagOut[d]), longint'(e.tag));
    endtask

    // Offers one job and returns just after the accepting edge; scrambles operands afterwards.
    task automatic applyStimulus(input int d, input logic [63:0][31:0] ops, input logic [1:0] op,
                                 input bit s, input bit t, input bit expectOut);
        exp_t e;
        int   n;
        e = refModel(widthOf(d), ops, op, s, t);
        @(posedge clk); #1;
        opsSh[d]   = ops;
        opSh[d]    = op;
        satSh[d]   = s;
        tagIn[d]   = t;
        inValid[d] = 1'b1;
        n = 0;
        @(negedge clk);
        while (!inReady[d] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!inReady[d]) begin
            checkOutput("accept_timeout", longint'(inReady[d]), 1);
            inValid[d] = 1'b0;
            return;
        end
        e.acc = cyc;
        if (expectOut) sbQ[d].push_back(e);
        @(posedge clk); #1;
        inValid[d] = 1'b0;
        for (int k = 0; k < 64; k++) opsSh[d][k] = $urandom();
        opSh[d]  = 2'($urandom_range(0, 3));
        satSh[d] = 1'($urandom_range(0, 1));
        tagIn[d] = 1'($urandom_range(0, 1));
    endtask

    task automatic waitValid(input int d);
        int n;
        n = 0;
        while (!outValid[d] && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("wait_valid", longint'(outValid[d]), 1);
    endtask

    task automatic drain(input int d);
        int n;
        n = 0;
        while (sbQ[d].size() > 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_pending_jobs", longint'(sbQ[d].size()), 0);
    endtask

    task automatic randomJob(input int d);
        logic [63:0][31:0] ops;
        for (int k = 0; k < 64; k++) ops[k] = 32'(randVal(widthOf(d)));
        applyStimulus(d, ops, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
        repeat ($urandom_range(0, 3)) @(posedge clk);
    endtask

    task automatic resetValuesDut0(input string name);
        checkOutput({name, "_valid"}, longint'(outValid[0]), 0);
        checkOutput({name, "_busy"}, longint'(busy[0]), 0);
        checkOutput({name, "_ovf"}, longint'(ovf[0]), 0);
        checkOutput({name, "_tag"}, longint'(tagOut[0]), 0);
        checkOutput({name, "_result_nonzero"}, longint'(|res0), 0);
    endtask

    task automatic directedSeq();
        logic [63:0][31:0] basic, layout, ovfOps, tmp;
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            basic[4*i] = 32'd7;  basic[4*i+1] = 32'd2;  basic[4*i+2] = 32'd1;       basic[4*i+3] = 32'd2;
            layout[4*i] = 32'(i); layout[4*i+1] = 32'(-i); layout[4*i+2] = 32'(100*i); layout[4*i+3] = 32'd3;
        end
        ovfOps = '0;
        ovfOps[0] = 32'd32767;
        ovfOps[2] = 32'd1;

        for (int op = 0; op < 4; op++) applyStimulus(0, basic, 2'(op), 1'b0, 1'b0, 1'b1);
        applyStimulus(0, layout, 2'd0, 1'b0, 1'b0, 1'b1);
        applyStimulus(0, ovfOps, 2'd0, 1'b1, 1'b0, 1'b1);
        applyStimulus(0, ovfOps, 2'd0, 1'b0, 1'b0, 1'b1);
        tmp = '0;
        tmp[1] = 32'hFFFF_8000;
        tmp[3] = 32'd1;
        applyStimulus(0, tmp, 2'd1, 1'b1, 1'b0, 1'b1);
        applyStimulus(0, layout, 2'd2, 1'b1, 1'b0, 1'b1);
        drain(0);

        // Backpressure: output must hold steady while the consumer stalls.
        rdyMode[0] = 2;
        e = refModel(16, basic, 2'd3, 1'b0, 1'b1);
        applyStimulus(0, basic, 2'd3, 1'b0, 1'b1, 1'b1);
        waitValid(0);
        repeat (10) begin
            checkResult("hold", 0, e);
            checkOutput("hold_in_ready", longint'(inReady[0]), 0);
            checkOutput("hold_busy", longint'(busy[0]), 1);
            @(negedge clk);
        end
        rdyMode[0] = 1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checkOutput("release_in_ready", longint'(inReady[0]), 1);
        checkOutput("release_valid", longint'(outValid[0]), 0);
        drain(0);

        // Flush at beat 2 with a competing job offered.
        applyStimulus(0, ovfOps, 2'd0, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        flush[0]   = 1'b1;
        inValid[0] = 1'b1;
        opsSh[0]   = layout;
        @(negedge clk);
        checkOutput("flush_in_ready", longint'(inReady[0]), 0);
        @(posedge clk); #1;
        flush[0]   = 1'b0;
        inValid[0] = 1'b0;
        @(negedge clk);
        checkOutput("flush_valid", longint'(outValid[0]), 0);
        checkOutput("flush_busy", longint'(busy[0]), 0);
        checkOutput("flush_in_ready_after", longint'(inReady[0]), 1);
        applyStimulus(0, layout, 2'd1, 1'b0, 1'b0, 1'b1);
        drain(0);

        // Same abort, but via reset.
        applyStimulus(0, ovfOps, 2'd0, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        rst[0]     = 1'b1;
        inValid[0] = 1'b1;
        @(negedge clk);
        checkOutput("midrun_reset_in_ready", longint'(inReady[0]), 0);
        @(posedge clk); #1;
        rst[0]     = 1'b0;
        inValid[0] = 1'b0;
        @(negedge clk);
        resetValuesDut0("midrun_reset");
        checkOutput("midrun_reset_in_ready_after", longint'(inReady[0]), 1);
        applyStimulus(0, layout, 2'd0, 1'b0, 1'b0, 1'b1);
        drain(0);

        rdyMode[0] = 0;
        repeat (20) randomJob(0);
        drain(0);
    endtask

    initial begin
        cyc = 0;
        forever @(posedge clk) cyc++;
    end

    initial begin
        outReady = '0;
        forever begin
            @(posedge clk); #1;
            for (int d = 0; d < NDUT; d++) begin
                case (rdyMode[d])
                    0:       outReady[d] = 1'($urandom_range(0, 1));
                    1:       outReady[d] = 1'b1;
                    default: outReady[d] = 1'b0;
                endcase
            end
        end
    end

    // Monitor: latency on each rising out_valid, full result compare on each output handshake.
    initial begin
        exp_t e;
        prevValid = '0;
        forever begin
            @(negedge clk);
            for (int d = 0; d < NDUT; d++) begin
                if (outValid[d] && !prevValid[d]) begin
                    if (sbQ[d].size() == 0) begin
                        checkOutput("unexpected_valid", longint'(outValid[d]), 0);
                    end else begin
                        checkOutput($sformatf("latency_dut%0d", d), longint'(cyc - sbQ[d][0].acc),
                                    longint'(beatsOf(d) + 1));
                    end
                end
                if (outValid[d] && outReady[d]) begin
                    if (sbQ[d].size() == 0) begin
                        checkOutput("unexpected_handshake", longint'(outValid[d]), 0);
                    end else begin
                        e = sbQ[d].pop_front();
                        checkResult($sformatf("job_dut%0d", d), d, e);
                    end
                end
                prevValid[d] = outValid[d];
            end
        end
    end

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = '1;
        inValid = '0;
        satSh   = '0;
        tagIn   = '0;
        flush   = '0;
        for (int d = 0; d < NDUT; d++) begin
            opSh[d]  = '0;
            opsSh[d] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_in_ready", longint'(inReady[0]), 0);
        resetValuesDut0("reset");
        @(posedge clk); #1;
        rst = '0;
        @(negedge clk);
        checkOutput("in_ready_after_reset", longint'(inReady[0]), 1);
        checkOutput("in_ready_after_reset_dut1", longint'(inReady[1]), 1);

        fork
            directedSeq();
            repeat (15) randomJob(1);
            repeat (15) randomJob(2);
        join
        for (int d = 0; d < NDUT; d++) drain(d);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/complex_matrix_addsub_stream.md
# complex_matrix_addsub_stream

Parametrised fixed-point complex matrix add/subtract engine that generalises our single-mode complex matrix adder. It accepts a whole SIZE-element complex operand pair in one handshake and processes LANES elements per cycle over SIZE/LANES beats. It supports four arithmetic modes, optional saturation, a per-job overflow flag and a passthrough tag. It sits behind the same valid/ready operand interface as the FP units and returns a full result matrix with a single output handshake.

## Interface
- WIDTH, 16: signed two's-complement width of each real/imag component (≥2).
- SIZE, 16: complex elements per job.
- LANES, 4: complex adders instantiated; SIZE % LANES == 0 required (elaboration error otherwise).
- TAG_WIDTH, 1: width of tag_i/tag_o.
- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- in_valid_i  in  1  job offered.
- in_ready_o  out  1  block can accept a job.
- operands_i  in  [SIZE*4][WIDTH]  element i: a_re=[4i], a_im=[4i+1], b_re=[4i+2], b_im=[4i+3].
- op_i  in  2  0 add a+b; 1 sub a−b; 2 a+conj(b); 3 reverse sub b−a.
- sat_i  in  1  1 saturate, 0 wrap.
- tag_i  in  TAG_WIDTH  carried to tag_o.
- flush_i  in  1  abort in-flight job.
- result_o  out  [SIZE*2][WIDTH]  element i: re=[2i], im=[2i+1].
- ovf_o  out  1  any component of the job overflowed WIDTH.
- tag_o  out  TAG_WIDTH  tag of the job in result_o.
- out_valid_o  out  1  result_o/ovf_o/tag_o valid.
- out_ready_i  in  1  consumer accepts result.
- busy_o  out  1  job in flight or held.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready_o=1. On in_valid_i&&in_ready_o, register operands_i, op_i, sat_i, tag_i, clear beat counter and ovf accumulator, go RUN. Inputs are don't-care after acceptance.
- RUN: each cycle, lanes l=0..LANES−1 process element beat*LANES+l and write its re/im into the result register. ovf accumulator ORs each lane's overflow. After beat SIZE/LANES−1, go DONE.
- DONE: out_valid_o=1; result_o, ovf_o and tag_o are held stable. On out_ready_i, go IDLE.
- Arithmetic: operands are sign-extended to WIDTH+1 bits before the add/subtract.
  - add: re=a_re+b_re, im=a_im+b_im.
  - sub: re=a_re−b_re, im=a_im−b_im.
  - conj: re=a_re+b_re, im=a_im−b_im.
  - rsub: re=b_re−a_re, im=b_im−a_im.
  - Overflow: the (WIDTH+1)-bit result does not fit in WIDTH bits.
  - sat_i=1 clamps to 2^(WIDTH−1)−1 / −2^(WIDTH−1). sat_i=0 truncates (wraps).
  - ovf_o reports overflow in both sat modes.
- busy_o = (state != IDLE).
- flush_i, in any state: go IDLE next edge, drop out_valid_o, and do not accept a job in the same cycle even if in_valid_i=1. result_o content after flush is undefined; ovf/tag from the flushed job must not leak into the next job.
- Priority: rst_i > flush_i > handshakes.

## Timing
- Reset values: state IDLE, out_valid_o=0, busy_o=0, ovf_o=0, tag_o=0, result_o=all 0. in_ready_o=0 while rst_i=1, and 1 on the first cycle after deassertion.
- Latency: the job is accepted at edge E0. Beats execute at edges E1..EN, where N=SIZE/LANES. out_valid_o is high from the cycle after EN.
- Default parameters give N=4. LANES=SIZE gives N=1. LANES=1 gives N=SIZE.
- The output handshake completes at the edge with out_valid_o&&out_ready_i. in_ready_o is 1 in the following cycle. Minimum initiation interval is N+2 cycles.
- in_ready_o is low in RUN and DONE. No input is buffered.
- Reset asserted mid-RUN or mid-DONE: all outputs return to their reset values at the next edge.

## Test plan
- All 16 elements a=(7,2), b=(1,2), sat=0, defaults. Expected per element:
  - op0 → (8,4); op1 → (6,0); op2 → (8,0); op3 → (0xFFFA,0).
  - ovf_o=0, out_valid_o high exactly 4 cycles after acceptance.
- Element i: a=(i, −i), b=(100·i, 3), op0. Expected result_o[2i]=101·i, result_o[2i+1]=3−i; verifies layout and lane/beat ordering.
- Overflow cases:
  - a_re=0x7FFF, b_re=1, op0, sat=1 → 0x7FFF, ovf_o=1.
  - Same with sat=0 → 0x8000, ovf_o=1.
  - a_im=0x8000, b_im=1, op1, sat=1 → 0x8000.
  - A following clean job → ovf_o=0.
- Backpressure: hold out_ready_i=0 for 10 cycles after out_valid_o. result_o, tag_o (tag=1) and ovf_o stay stable; in_ready_o=0 and busy_o=1 throughout. Release → in_ready_o=1 the next cycle.
- Pulse flush_i at beat 2 with in_valid_i=1. out_valid_o never rises for that job, and no acceptance occurs in the flush cycle. The next job returns correct results with ovf_o=0. Repeat with rst_i pulsed mid-RUN instead of flush_i.
- Parameter sweep: LANES ∈ {1,4,16}, WIDTH ∈ {8,16,32} with random operands against a reference model. Latency is 16/4/1 cycles respectively; all results and ovf_o are bit-exact.
